// File: rtl/veggie_pkg.sv
// Shared screen geometry, command opcodes and FSM states
// for the frame drawing engine.
package veggie_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int FB_DEPTH = SCREEN_W * SCREEN_H;

    localparam logic [7:0] TRANSPARENT = 8'hE3;

    typedef enum logic [1:0] {
        OP_CLEAR  = 2'd0,
        OP_FILL   = 2'd1,
        OP_SPRITE = 2'd2,
        OP_NOP    = 2'd3
    } draw_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_SPRITE,
        S_DRAIN,
        S_DONE
    } draw_state_t;

    // y * SCREEN_W built from shifts: 640 = 512 + 128
    function automatic logic [18:0] row_base(input logic [9:0] y);
        return ({9'b0, y} << 9) + ({9'b0, y} << 7);
    endfunction

endpackage

// File: rtl/frame_drawer_if.sv
// Command, sprite ROM and frame buffer write port bundle
// between the host block and the drawing engine.
interface frame_drawer_if;
    import veggie_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    draw_op_t    cmd_op;
    logic [9:0]  cmd_x;
    logic [9:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [9:0]  cmd_h;
    logic [7:0]  cmd_color;
    logic [15:0] cmd_sprite_base;
    logic [15:0] sprite_rdAddress;
    logic [7:0]  sprite_data;
    logic [18:0] frame_wrAddress;
    logic [7:0]  frame_input;
    logic        frame_we;
    logic        busy;
    logic        done;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h,
        output cmd_color, cmd_sprite_base, sprite_data,
        input  cmd_ready, sprite_rdAddress,
        input  frame_wrAddress, frame_input, frame_we, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h,
        input  cmd_color, cmd_sprite_base, sprite_data,
        output cmd_ready, sprite_rdAddress,
        output frame_wrAddress, frame_input, frame_we, busy, done
    );

endinterface

// File: rtl/rect_scanner.sv
// Row-major rectangle walker: column/row counters, incremental
// frame and sprite addresses, and the off-screen clip flag.
module rect_scanner
    import veggie_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [9:0]  w,
    input  logic [9:0]  h,
    input  logic [15:0] base,
    output logic [18:0] addr,
    output logic [18:0] addr_nxt,
    output logic [15:0] saddr,
    output logic        clip,
    output logic        clip_nxt,
    output logic        last
);

    logic [10:0] col, row, x0, xend, yend;
    logic [10:0] col_n, row_n, x0_n, xend_n, yend_n;
    logic [18:0] rbase, rbase_n;
    logic [15:0] saddr_n;
    logic        wrap;

    assign wrap = (col == xend);
    assign last = wrap && (row == yend);

    always_comb begin
        col_n    = col;
        row_n    = row;
        x0_n     = x0;
        xend_n   = xend;
        yend_n   = yend;
        rbase_n  = rbase;
        addr_nxt = addr;
        saddr_n  = saddr;
        if (load) begin
            col_n    = {1'b0, x};
            row_n    = {1'b0, y};
            x0_n     = {1'b0, x};
            xend_n   = {1'b0, x} + {1'b0, w} - 11'd1;
            yend_n   = {1'b0, y} + {1'b0, h} - 11'd1;
            rbase_n  = row_base(y);
            addr_nxt = rbase_n + {9'b0, x};
            saddr_n  = base;
        end else if (step) begin
            saddr_n = saddr + 16'd1;
            if (wrap) begin
                col_n    = x0;
                row_n    = row + 11'd1;
                rbase_n  = rbase + 19'(SCREEN_W);
                addr_nxt = rbase_n + {8'b0, x0};
            end else begin
                col_n    = col + 11'd1;
                addr_nxt = addr + 19'd1;
            end
        end
        clip_nxt = (col_n >= 11'(SCREEN_W)) || (row_n >= 11'(SCREEN_H));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col   <= '0;
            row   <= '0;
            x0    <= '0;
            xend  <= '0;
            yend  <= '0;
            rbase <= '0;
            addr  <= '0;
            saddr <= '0;
            clip  <= 1'b0;
        end else begin
            col   <= col_n;
            row   <= row_n;
            x0    <= x0_n;
            xend  <= xend_n;
            yend  <= yend_n;
            rbase <= rbase_n;
            addr  <= addr_nxt;
            saddr <= saddr_n;
            clip  <= clip_nxt;
        end
    end

endmodule

// File: rtl/frame_drawer.sv
// Drawing engine: turns clear/fill/sprite commands into a
// stream of single-pixel frame buffer writes.
module frame_drawer
    import veggie_pkg::*;
(
    input  logic           Clk,
    input  logic           Reset,
    frame_drawer_if.slave  bus
);

    draw_state_t state, state_d;
    logic        accept, load, step, degenerate, is_clear;
    logic [9:0]  sx, sy, sw, sh;
    logic [18:0] addr, addr_nxt;
    logic [15:0] saddr;
    logic        clip, clip_nxt, last;
    logic [7:0]  color;
    logic        we_d;
    logic [18:0] wa_d;
    logic [7:0]  px_d;

    assign accept     = bus.cmd_valid && bus.cmd_ready;
    assign degenerate = (bus.cmd_w == 10'd0) || (bus.cmd_h == 10'd0);
    assign is_clear   = (bus.cmd_op == OP_CLEAR);

    // CLEAR is the full-screen rectangle, giving ascending addresses
    assign sx = is_clear ? 10'd0 : bus.cmd_x;
    assign sy = is_clear ? 10'd0 : bus.cmd_y;
    assign sw = is_clear ? 10'(SCREEN_W) : bus.cmd_w;
    assign sh = is_clear ? 10'(SCREEN_H) : bus.cmd_h;

    assign load = accept &&
                  (state_d inside {S_CLEAR, S_FILL, S_SPRITE});
    assign step = (state inside {S_CLEAR, S_FILL, S_SPRITE}) && !last;

    assign bus.sprite_rdAddress = saddr;

    rect_scanner u_scan (
        .clk      (Clk),
        .rst      (Reset),
        .load     (load),
        .step     (step),
        .x        (sx),
        .y        (sy),
        .w        (sw),
        .h        (sh),
        .base     (bus.cmd_sprite_base),
        .addr     (addr),
        .addr_nxt (addr_nxt),
        .saddr    (saddr),
        .clip     (clip),
        .clip_nxt (clip_nxt),
        .last     (last)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    unique case (bus.cmd_op)
                        OP_CLEAR:  state_d = S_CLEAR;
                        OP_FILL:   state_d = degenerate ? S_DONE : S_FILL;
                        OP_SPRITE: state_d = degenerate ? S_DONE : S_SPRITE;
                        default:   state_d = S_DONE;
                    endcase
                end
            end
            S_CLEAR, S_FILL: if (last) state_d = S_DONE;
            S_SPRITE:        if (last) state_d = S_DRAIN;
            S_DRAIN:         state_d = S_DONE;
            default:         state_d = S_IDLE;
        endcase
    end

    // Sprite writes trail the ROM address by one cycle to meet the data
    always_comb begin
        we_d = 1'b0;
        wa_d = bus.frame_wrAddress;
        px_d = bus.frame_input;
        if (state_d == S_CLEAR || state_d == S_FILL) begin
            we_d = !clip_nxt;
            wa_d = addr_nxt;
            px_d = accept ? bus.cmd_color : color;
        end else if (state == S_SPRITE) begin
            we_d = !clip && (bus.sprite_data != TRANSPARENT);
            wa_d = addr;
            px_d = bus.sprite_data;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            color               <= '0;
            bus.cmd_ready       <= 1'b1;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.frame_we        <= 1'b0;
            bus.frame_wrAddress <= '0;
            bus.frame_input     <= '0;
        end else begin
            if (accept) color <= bus.cmd_color;
            bus.cmd_ready       <= (state_d == S_IDLE);
            bus.busy            <= (state_d != S_IDLE);
            bus.done            <= (state_d == S_DONE);
            bus.frame_we        <= we_d;
            bus.frame_wrAddress <= wa_d;
            bus.frame_input     <= px_d;
        end
    end

endmodule

// File: tb/tb_frame_drawer.sv
// Directed bench for frame_drawer: clear, fill, clipping,
// sprite transparency, reset abort and degenerate commands.
module tb_frame_drawer;
    import veggie_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] rom [0:255];

    frame_drawer_if bus ();

    frame_drawer dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ROM data for the presented address is sampled by the engine at the next edge
    assign bus.sprite_data = rom[bus.sprite_rdAddress[7:0]];

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input draw_op_t op,
                        input logic [9:0] x, input logic [9:0] y,
                        input logic [9:0] w, input logic [9:0] h,
                        input logic [7:0] c, input logic [15:0] b);
        bus.cmd_op = op;
        bus.cmd_x = x;
        bus.cmd_y = y;
        bus.cmd_w = w;
        bus.cmd_h = h;
        bus.cmd_color = c;
        bus.cmd_sprite_base = b;
        bus.cmd_valid = 1'b1;
        check("ready_before_cmd", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op = OP_CLEAR;
        bus.cmd_x = 10'h3FF;
        bus.cmd_y = 10'h3FF;
        bus.cmd_w = 10'h155;
        bus.cmd_h = 10'h2AA;
        bus.cmd_color = 8'h5A;
        bus.cmd_sprite_base = 16'hBEEF;
    endtask

    int fill_a [6] = '{1290, 1291, 1292, 1930, 1931, 1932};
    int clip_we [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    int clip_a [2] = '{307198, 307199};
    int spr_ra [4] = '{100, 101, 102, 103};
    int spr_we [4] = '{1, 0, 1, 1};
    int spr_wa [4] = '{0, 1, 640, 641};
    int spr_px [4] = '{8'h03, 8'hE3, 8'h10, 8'h20};
    int bad;
    int seen;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[100] = 8'h03;
        rom[101] = 8'hE3;
        rom[102] = 8'h10;
        rom[103] = 8'h20;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = OP_NOP;
        bus.cmd_x = '0;
        bus.cmd_y = '0;
        bus.cmd_w = '0;
        bus.cmd_h = '0;
        bus.cmd_color = '0;
        bus.cmd_sprite_base = '0;
        tick();
        tick();
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_we", bus.frame_we, 0);
        check("rst_wa", bus.frame_wrAddress, 0);
        check("rst_px", bus.frame_input, 0);
        check("rst_ra", bus.sprite_rdAddress, 0);
        rst = 1'b0;
        tick();

        // CLEAR: first 2048 writes, then abandoned by reset
        send(OP_CLEAR, 10'd7, 10'd9, 10'd3, 10'd3, 8'h1C, 16'd0);
        check("clr_busy", bus.busy, 1);
        check("clr_ready", bus.cmd_ready, 0);
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            if (!(bus.frame_we === 1'b1 &&
                  bus.frame_wrAddress === 19'(i) &&
                  bus.frame_input === 8'h1C)) bad++;
            if (i < 2047) tick();
        end
        check("clr_stream", bad, 0);
        rst = 1'b1;
        #1;
        check("clr_rst_we", bus.frame_we, 0);
        check("clr_rst_ready", bus.cmd_ready, 1);
        #2;
        rst = 1'b0;
        tick();

        // FILL 3x2 at (10,2)
        send(OP_FILL, 10'd10, 10'd2, 10'd3, 10'd2, 8'hFF, 16'd0);
        for (int i = 0; i < 6; i++) begin
            check("fill_we", bus.frame_we, 1);
            check("fill_wa", bus.frame_wrAddress, fill_a[i]);
            check("fill_px", bus.frame_input, 8'hFF);
            check("fill_done_low", bus.done, 0);
            tick();
        end
        check("fill_done", bus.done, 1);
        check("fill_we_end", bus.frame_we, 0);
        check("fill_ready_in_done", bus.cmd_ready, 0);
        tick();
        check("fill_done_pulse", bus.done, 0);
        check("fill_ready_back", bus.cmd_ready, 1);
        check("fill_busy_end", bus.busy, 0);

        // FILL clipped at the bottom-right corner
        send(OP_FILL, 10'd638, 10'd479, 10'd4, 10'd2, 8'h55, 16'd0);
        for (int i = 0; i < 8; i++) begin
            check("clip_we", bus.frame_we, clip_we[i]);
            if (i < 2) check("clip_wa", bus.frame_wrAddress, clip_a[i]);
            check("clip_done_low", bus.done, 0);
            tick();
        end
        check("clip_done", bus.done, 1);
        tick();
        tick();

        // SPRITE 2x2 with one transparent pixel
        send(OP_SPRITE, 10'd0, 10'd0, 10'd2, 10'd2, 8'h00, 16'd100);
        check("spr_ra0", bus.sprite_rdAddress, spr_ra[0]);
        check("spr_we0", bus.frame_we, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) check("spr_ra", bus.sprite_rdAddress, spr_ra[i+1]);
            check("spr_we", bus.frame_we, spr_we[i]);
            if (spr_we[i] == 1) begin
                check("spr_wa", bus.frame_wrAddress, spr_wa[i]);
                check("spr_px", bus.frame_input, spr_px[i]);
            end
            check("spr_done_low", bus.done, 0);
        end
        tick();
        check("spr_done", bus.done, 1);
        check("spr_we_end", bus.frame_we, 0);
        tick();
        tick();

        // Reset after the third write of a FILL
        send(OP_FILL, 10'd0, 10'd0, 10'd8, 10'd1, 8'h77, 16'd0);
        for (int i = 0; i < 3; i++) begin
            check("abort_wa", bus.frame_wrAddress, i);
            check("abort_we", bus.frame_we, 1);
            if (i < 2) tick();
        end
        rst = 1'b1;
        #1;
        check("abort_we_drop", bus.frame_we, 0);
        check("abort_ready", bus.cmd_ready, 1);
        check("abort_busy", bus.busy, 0);
        #2;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.frame_we === 1'b1 || bus.done === 1'b1) seen++;
        end
        check("abort_quiet", seen, 0);

        send(OP_FILL, 10'd5, 10'd1, 10'd2, 10'd1, 8'hAA, 16'd0);
        check("refill_wa0", bus.frame_wrAddress, 645);
        check("refill_px0", bus.frame_input, 8'hAA);
        tick();
        check("refill_wa1", bus.frame_wrAddress, 646);
        check("refill_we1", bus.frame_we, 1);
        tick();
        check("refill_done", bus.done, 1);
        tick();
        tick();

        // Degenerate and reserved commands
        send(OP_FILL, 10'd3, 10'd3, 10'd0, 10'd4, 8'h11, 16'd0);
        check("w0_done", bus.done, 1);
        check("w0_we", bus.frame_we, 0);
        tick();
        check("w0_ready", bus.cmd_ready, 1);
        check("w0_we2", bus.frame_we, 0);
        send(OP_SPRITE, 10'd3, 10'd3, 10'd4, 10'd0, 8'h11, 16'd50);
        check("h0_done", bus.done, 1);
        check("h0_we", bus.frame_we, 0);
        tick();
        send(OP_NOP, 10'd1, 10'd1, 10'd5, 10'd5, 8'h22, 16'd0);
        check("nop_done", bus.done, 1);
        check("nop_we", bus.frame_we, 0);
        tick();
        check("nop_ready", bus.cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
